// File: rtl/mips_multicycle_core.sv
// ----------------------------------------------------------------------------
// mips_multicycle_core
//   Multi-cycle MIPS32 integer core. One FSM steps each instruction through
//   FETCH / DECODE / EXEC / MEM / WB and shares a single memory port, with a
//   req/ready handshake, between instruction fetch and lw/sw. Any memory
//   latency is absorbed by waiting in FETCH or MEM.
//
//   Supported: add sub and or slt jr addi lw sw beq j jal.
//   Any other opcode/funct, or a misaligned lw/sw, halts the core with
//   illegal=1 until rst.
//
// Parameters
//   RESET_PC   PC loaded on reset (word aligned)
//   ADDR_W     width of pc and mem_addr (byte address, upper bits dropped)
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   mem_req/we      access request (held until mem_ready), 1 = store
//   mem_addr        word-aligned byte address of the access
//   mem_wdata       store data
//   mem_rdata       load/fetch data, taken when req & ready & !we
//   mem_ready       completes the access in any cycle where req is high
//   pc              address of the next instruction to fetch
//   retire          one-cycle pulse in the last cycle of each instruction
//   halted/illegal  sticky stop flags, cleared only by rst
// ----------------------------------------------------------------------------
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              retire,
    output logic              halted,
    output logic              illegal
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    state_t            state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [31:0]       ir_reg, a_reg, b_reg, alu_out_reg, mdr_reg;
    logic              mem_req_reg, mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [31:0]       mem_wdata_reg;
    logic              halted_reg, illegal_reg;

    logic [31:0] regs [32];

    // ------------------------------------------------------------------
    // Instruction fields and decode (IR is stable from DECODE onwards)
    // ------------------------------------------------------------------
    logic [5:0]  opcode, funct;
    logic [4:0]  rs_idx, rt_idx, rd_idx;
    logic [31:0] simm;
    logic        is_rtype, is_jr, is_ralu, is_addi, is_lw, is_sw, is_beq, is_j, is_jal;
    logic        legal;

    assign opcode = ir_reg[31:26];
    assign funct  = ir_reg[5:0];
    assign rs_idx = ir_reg[25:21];
    assign rt_idx = ir_reg[20:16];
    assign rd_idx = ir_reg[15:11];
    assign simm   = {{16{ir_reg[15]}}, ir_reg[15:0]};

    assign is_rtype = (opcode == OP_RTYPE);
    assign is_jr    = is_rtype && (funct == F_JR);
    assign is_ralu  = is_rtype && ((funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                                   (funct == F_OR)  || (funct == F_SLT));
    assign is_addi  = (opcode == OP_ADDI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_j     = (opcode == OP_J);
    assign is_jal   = (opcode == OP_JAL);
    assign legal    = is_ralu | is_jr | is_addi | is_lw | is_sw | is_beq | is_j | is_jal;

    // ------------------------------------------------------------------
    // Address arithmetic. pc_reg already points past the current
    // instruction when these are used, so targets have no delay slot.
    // ------------------------------------------------------------------
    logic [31:0]       pc32, mem_ea;
    logic [ADDR_W-1:0] pc_plus4, jump_target, branch_target;

    assign pc32          = 32'(pc_reg);
    assign pc_plus4      = pc_reg + ADDR_W'(4);
    assign jump_target   = ADDR_W'({pc32[31:28], ir_reg[25:0], 2'b00});
    assign branch_target = ADDR_W'(pc32 + (simm << 2));
    assign mem_ea        = a_reg + simm;

    // ------------------------------------------------------------------
    // ALU for R-type and addi (wrapping arithmetic, signed slt)
    // ------------------------------------------------------------------
    logic [31:0] alu_result;

    always_comb begin
        alu_result = '0;
        if (is_addi) begin
            alu_result = a_reg + simm;
        end else begin
            case (funct)
                F_ADD:   alu_result = a_reg + b_reg;
                F_SUB:   alu_result = a_reg - b_reg;
                F_AND:   alu_result = a_reg & b_reg;
                F_OR:    alu_result = a_reg | b_reg;
                F_SLT:   alu_result = {31'b0, ($signed(a_reg) < $signed(b_reg))};
                default: alu_result = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register file: read into A/B in DECODE, written in WB or by jal
    // ------------------------------------------------------------------
    logic [31:0] rs_val, rt_val;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    assign rs_val = (rs_idx == 5'd0) ? 32'd0 : regs[rs_idx];
    assign rt_val = (rt_idx == 5'd0) ? 32'd0 : regs[rt_idx];

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (state_reg == S_WB) begin
            rf_we = 1'b1;
            if (is_rtype) begin
                rf_waddr = rd_idx;
                rf_wdata = alu_out_reg;
            end else begin
                rf_waddr = rt_idx;
                rf_wdata = is_lw ? mdr_reg : alu_out_reg;
            end
        end else if ((state_reg == S_DECODE) && is_jal) begin
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = pc32;   // return address: pc was already advanced in FETCH
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    // ------------------------------------------------------------------
    // retire marks the final cycle of an instruction. A store only ends
    // when its memory access is accepted, so this cannot be registered.
    // ------------------------------------------------------------------
    always_comb begin
        retire = 1'b0;
        case (state_reg)
            S_DECODE: retire = is_j | is_jal;
            S_EXEC:   retire = is_beq | is_jr;
            S_MEM:    retire = is_sw & mem_req_reg & mem_ready;
            S_WB:     retire = 1'b1;
            default:  retire = 1'b0;
        endcase
        if (rst) begin
            retire = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Main sequencer. Every transition back to FETCH raises mem_req with
    // the next fetch address in the same edge, so a zero-wait fetch takes
    // one cycle. Only the very first fetch after reset spends an extra
    // cycle issuing its request (mem_req comes out of reset low).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_FETCH;
            pc_reg        <= ADDR_W'(RESET_PC);
            ir_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            alu_out_reg   <= '0;
            mdr_reg       <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            halted_reg    <= 1'b0;
            illegal_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (!mem_req_reg) begin
                        mem_req_reg  <= 1'b1;
                        mem_we_reg   <= 1'b0;
                        mem_addr_reg <= pc_reg;
                    end else if (mem_ready) begin
                        ir_reg      <= mem_rdata;
                        pc_reg      <= pc_plus4;
                        mem_req_reg <= 1'b0;
                        state_reg   <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    a_reg <= rs_val;
                    b_reg <= rt_val;
                    if (is_j || is_jal) begin
                        pc_reg       <= jump_target;
                        mem_req_reg  <= 1'b1;
                        mem_we_reg   <= 1'b0;
                        mem_addr_reg <= jump_target;
                        state_reg    <= S_FETCH;
                    end else if (!legal) begin
                        halted_reg  <= 1'b1;
                        illegal_reg <= 1'b1;
                        state_reg   <= S_HALT;
                    end else begin
                        state_reg <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (is_lw || is_sw) begin
                        alu_out_reg <= mem_ea;
                        if (mem_ea[1:0] != 2'b00) begin
                            halted_reg  <= 1'b1;
                            illegal_reg <= 1'b1;
                            state_reg   <= S_HALT;
                        end else begin
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= is_sw;
                            mem_addr_reg  <= ADDR_W'(mem_ea);
                            mem_wdata_reg <= b_reg;
                            state_reg     <= S_MEM;
                        end
                    end else if (is_beq) begin
                        mem_req_reg <= 1'b1;
                        mem_we_reg  <= 1'b0;
                        state_reg   <= S_FETCH;
                        if (a_reg == b_reg) begin
                            pc_reg       <= branch_target;
                            mem_addr_reg <= branch_target;
                        end else begin
                            mem_addr_reg <= pc_reg;
                        end
                    end else if (is_jr) begin
                        pc_reg       <= ADDR_W'(a_reg);
                        mem_req_reg  <= 1'b1;
                        mem_we_reg   <= 1'b0;
                        mem_addr_reg <= ADDR_W'(a_reg);
                        state_reg    <= S_FETCH;
                    end else begin
                        alu_out_reg <= alu_result;
                        state_reg   <= S_WB;
                    end
                end

                S_MEM: begin
                    if (mem_ready) begin
                        if (is_sw) begin
                            // store done: chain straight into the next fetch
                            mem_we_reg   <= 1'b0;
                            mem_addr_reg <= pc_reg;
                            state_reg    <= S_FETCH;
                        end else begin
                            mdr_reg     <= mem_rdata;
                            mem_req_reg <= 1'b0;
                            state_reg   <= S_WB;
                        end
                    end
                end

                S_WB: begin
                    mem_req_reg  <= 1'b1;
                    mem_we_reg   <= 1'b0;
                    mem_addr_reg <= pc_reg;
                    state_reg    <= S_FETCH;
                end

                S_HALT: begin
                    mem_req_reg <= 1'b0;
                end

                default: begin
                    state_reg <= S_HALT;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign pc        = pc_reg;
    assign halted    = halted_reg;
    assign illegal   = illegal_reg;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// ----------------------------------------------------------------------------
// tb_mips_multicycle_core
//   Directed programs for mips_multicycle_core (RESET_PC = 0x10). A
//   word-addressed memory model with a programmable number of wait cycles
//   answers the core's memory port, and records completed reads and retire
//   timestamps.
// ----------------------------------------------------------------------------
module tb_mips_multicycle_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] pc;
    logic        retire, halted, illegal;

    always #5 clk = ~clk;

    mips_multicycle_core #(
        .RESET_PC (32'h0000_0010),
        .ADDR_W   (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc        (pc),
        .retire    (retire),
        .halted    (halted),
        .illegal   (illegal)
    );

    logic [31:0] mem [64];
    int          wait_cycles = 0;
    int          wait_cnt    = 0;
    int          cyc         = 0;
    int          ret_count   = 0;
    int          read_count  = 0;
    int          ret_stamp [64];
    logic [31:0] read_log  [64];
    int          stab_err    = 0;
    logic        prev_wait   = 1'b0;
    logic        prev_we     = 1'b0;
    logic [31:0] prev_addr   = '0;
    logic [31:0] prev_wdata  = '0;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] target);
        return {op, target[27:2]};
    endfunction

    // ---------------- memory model (acts on falling edges) ----------------
    initial begin : mem_model
        forever begin
            @(negedge clk);
            // request must not change while it is still waiting
            if (prev_wait) begin
                if (!mem_req || mem_addr !== prev_addr || mem_we !== prev_we ||
                    (mem_we && mem_wdata !== prev_wdata)) begin
                    stab_err++;
                end
            end
            if (rst || !mem_req) begin
                wait_cnt  = 0;
                mem_ready = (wait_cycles == 0);
            end else if (wait_cnt >= wait_cycles) begin
                mem_ready = 1'b1;
                wait_cnt  = 0;
                if (mem_we) begin
                    mem[mem_addr[7:2]] = mem_wdata;
                end else if (read_count < 64) begin
                    read_log[read_count] = mem_addr;
                    read_count++;
                end
            end else begin
                mem_ready = 1'b0;
                wait_cnt++;
            end
            mem_rdata  = mem[mem_addr[7:2]];
            prev_wait  = mem_req && !mem_ready && !rst;
            prev_addr  = mem_addr;
            prev_we    = mem_we;
            prev_wdata = mem_wdata;
            #1;
            if (!rst) begin
                cyc++;
                if (retire && ret_count < 64) begin
                    ret_stamp[ret_count] = cyc;
                    ret_count++;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // hold reset, clear memory and logs; caller loads a program then releases rst
    task automatic reset_begin(input int waits);
        rst = 1'b1;
        tick(2);
        wait_cycles = waits;
        for (int k = 0; k < 64; k++) begin
            mem[k] = '0;
        end
        cyc        = 0;
        ret_count  = 0;
        read_count = 0;
        stab_err   = 0;
    endtask

    task automatic run_retires(input int target, input int budget);
        int n;
        n = 0;
        while (ret_count < target && n < budget) begin
            tick(1);
            n++;
        end
        check("retire_count_reached", 32'(ret_count >= target), 32'd1);
    endtask

    function automatic logic [31:0] ivl(input int idx);
        return 32'(ret_stamp[idx] - ret_stamp[idx - 1]);
    endfunction

    logic [31:0] exp_reads [12];

    initial begin : stim
        int found;

        // ---- A: ALU sequence, zero-wait memory ----
        reset_begin(0);
        mem[4] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);        // addi r1,r0,5
        mem[5] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);     // addi r2,r0,-3
        mem[6] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);         // add  r3,r1,r2
        mem[7] = enc_i(6'h04, 5'd1, 5'd2, 16'd4);        // beq  r1,r2,+4 (not taken)
        mem[8] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);     // beq  r0,r0,-1 (park at 0x20)
        check("rst_pc",      pc,              32'h10);
        check("rst_mem_req", 32'(mem_req),    32'd0);
        check("rst_retire",  32'(retire),     32'd0);
        check("rst_halted",  32'(halted),     32'd0);
        check("rst_illegal", 32'(illegal),    32'd0);
        rst = 1'b0;
        run_retires(6, 200);
        check("A_ivl_addi",     ivl(1), 32'd4);
        check("A_ivl_add",      ivl(2), 32'd4);
        check("A_ivl_beq_nt",   ivl(3), 32'd3);
        check("A_ivl_beq_t",    ivl(4), 32'd3);
        check("A_ivl_beq_loop", ivl(5), 32'd3);
        check("A_r1", dut.regs[1], 32'd5);
        check("A_r2", dut.regs[2], 32'hFFFF_FFFD);
        check("A_r3", dut.regs[3], 32'd2);
        check("A_fetch3", read_log[3], 32'h1C);
        check("A_fetch4", read_log[4], 32'h20);
        check("A_fetch5", read_log[5], 32'h20);

        // ---- B: store/load with 3 wait cycles per access ----
        reset_begin(3);
        mem[4] = enc_i(6'h08, 5'd0, 5'd3, 16'd2);        // addi r3,r0,2
        mem[5] = enc_i(6'h2B, 5'd0, 5'd3, 16'd8);        // sw   r3,8(r0)
        mem[6] = enc_i(6'h23, 5'd0, 5'd4, 16'd8);        // lw   r4,8(r0)
        mem[7] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);     // beq  r0,r0,-1
        rst = 1'b0;
        run_retires(4, 300);
        check("B_ivl_sw",  ivl(1), 32'd10);
        check("B_ivl_lw",  ivl(2), 32'd11);
        check("B_ivl_beq", ivl(3), 32'd6);
        check("B_mem8",    mem[2], 32'd2);
        check("B_r4",      dut.regs[4], 32'd2);
        check("B_req_stable_errors", 32'(stab_err), 32'd0);

        // ---- C: jal / jr, r0 write ignored, remaining R-type ops ----
        reset_begin(0);
        mem[4]  = enc_i(6'h08, 5'd0, 5'd0, 16'd7);       // 0x10 addi r0,r0,7
        mem[5]  = enc_i(6'h08, 5'd0, 5'd6, 16'd1);       // 0x14 addi r6,r0,1
        mem[6]  = enc_i(6'h08, 5'd6, 5'd6, 16'd1);       // 0x18 addi r6,r6,1
        mem[7]  = enc_i(6'h08, 5'd0, 5'd7, 16'hFFFF);    // 0x1C addi r7,r0,-1
        mem[8]  = enc_j(6'h03, 32'h40);                  // 0x20 jal  0x40
        mem[9]  = enc_i(6'h08, 5'd0, 5'd8, 16'd9);       // 0x24 addi r8,r0,9
        mem[10] = enc_r(5'd7, 5'd6, 5'd9, 6'h2A);        // 0x28 slt  r9,r7,r6
        mem[11] = enc_r(5'd6, 5'd7, 5'd10, 6'h22);       // 0x2C sub  r10,r6,r7
        mem[12] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);    // 0x30 beq  r0,r0,-1
        mem[16] = enc_r(5'd6, 5'd7, 5'd11, 6'h25);       // 0x40 or   r11,r6,r7
        mem[17] = enc_r(5'd7, 5'd6, 5'd12, 6'h24);       // 0x44 and  r12,r7,r6
        mem[18] = enc_r(5'd31, 5'd0, 5'd0, 6'h08);       // 0x48 jr   r31
        exp_reads = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h40,
                      32'h44, 32'h48, 32'h24, 32'h28, 32'h2C, 32'h30};
        rst = 1'b0;
        run_retires(12, 300);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("C_fetch%0d", k), read_log[k], exp_reads[k]);
        end
        check("C_ivl_jal", ivl(4), 32'd2);
        check("C_ivl_jr",  ivl(7), 32'd3);
        check("C_r0",  dut.regs[0],  32'd0);
        check("C_r31", dut.regs[31], 32'h24);
        check("C_r8",  dut.regs[8],  32'd9);
        check("C_r9_slt", dut.regs[9],  32'd1);
        check("C_r10_sub", dut.regs[10], 32'd3);
        check("C_r11_or",  dut.regs[11], 32'hFFFF_FFFF);
        check("C_r12_and", dut.regs[12], 32'd2);

        // ---- D: unsupported opcode 0x3F ----
        reset_begin(0);
        mem[4] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);        // addi r1,r0,1
        mem[5] = 32'hFC00_0000;                           // opcode 6'h3F
        rst = 1'b0;
        tick(30);
        check("D_halted",  32'(halted),    32'd1);
        check("D_illegal", 32'(illegal),   32'd1);
        check("D_mem_req", 32'(mem_req),   32'd0);
        check("D_pc",      pc,             32'h18);
        check("D_retires", 32'(ret_count), 32'd1);
        tick(5);
        check("D_pc_frozen",    pc,          32'h18);
        check("D_halted_stays", 32'(halted), 32'd1);

        // ---- E: misaligned load address ----
        reset_begin(0);
        mem[4] = enc_i(6'h23, 5'd0, 5'd2, 16'd2);        // lw r2,2(r0)
        rst = 1'b0;
        tick(20);
        check("E_halted",  32'(halted),     32'd1);
        check("E_illegal", 32'(illegal),    32'd1);
        check("E_mem_req", 32'(mem_req),    32'd0);
        check("E_pc",      pc,              32'h14);
        check("E_reads",   32'(read_count), 32'd1);
        check("E_retires", 32'(ret_count),  32'd0);

        // ---- F: reset in the middle of a waiting store ----
        reset_begin(5);
        mem[4] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);        // addi r1,r0,5
        mem[5] = enc_i(6'h2B, 5'd0, 5'd1, 16'd4);        // sw   r1,4(r0)
        mem[6] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);     // beq  r0,r0,-1
        rst = 1'b0;
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            tick(1);
            if (mem_req && mem_we) found = 1;
        end
        check("F_store_reached", 32'(found), 32'd1);
        tick(2);
        check("F_r1_before", dut.regs[1], 32'd5);
        rst = 1'b1;
        tick(1);
        check("F_rst_mem_req", 32'(mem_req), 32'd0);
        check("F_rst_pc",      pc,           32'h10);
        check("F_rst_r1",      dut.regs[1],  32'd0);
        check("F_rst_halted",  32'(halted),  32'd0);
        check("F_no_store",    mem[1],       32'd0);
        rst = 1'b0;
        tick(1);
        check("F_fetch_req",  32'(mem_req), 32'd1);
        check("F_fetch_addr", mem_addr,     32'h10);
        check("F_fetch_we",   32'(mem_we),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
